// File: rtl/square_pkg.sv
// Shared types and constants for the square-pattern sequencer: modes, width codes, colour palette.
package square_pkg;

  typedef enum logic [1:0] {
    ModeManual    = 2'b00,
    ModeAutoSize  = 2'b01,
    ModeAutoColor = 2'b10,
    ModeAutoBoth  = 2'b11
  } mode_e;

  localparam logic [1:0] W16  = 2'b00;
  localparam logic [1:0] W32  = 2'b01;
  localparam logic [1:0] W64  = 2'b10;
  localparam logic [1:0] W128 = 2'b11;

  // Entry i is {b,g,r}; each channel is fully on when its bit of i is set.
  localparam logic [7:0][11:0] Palette = {
    12'hFFF, 12'hFF0, 12'hF0F, 12'hF00,
    12'h0FF, 12'h0F0, 12'h00F, 12'h000
  };

  function automatic logic size_step_is_size(mode_e mode);
    return (mode == ModeAutoSize) || (mode == ModeAutoBoth);
  endfunction

  function automatic logic size_step_is_color(mode_e mode);
    return (mode == ModeAutoColor) || (mode == ModeAutoBoth);
  endfunction

endpackage

// File: rtl/square_step_timer.sv
// Frame counter that raises a one-cycle step request when it wraps at FRAMES_PER_STEP-1.
module square_step_timer #(
  parameter int unsigned FRAMES_PER_STEP = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic frame_tick,
  output logic step
);

  localparam logic [7:0] LastCount = 8'(FRAMES_PER_STEP - 1);

  logic [7:0] count_q, count_d;
  logic       advance;
  logic       at_last;

  always_comb begin
    advance = frame_tick && en && !clear;
    at_last = (count_q == LastCount);
    step    = advance && at_last;
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (advance) begin
      count_d = at_last ? 8'd0 : count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/square_seq_ctrl.sv
// Frame-synchronous controller choosing size and colour of the generated square.
module square_seq_ctrl
  import square_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [1:0]  mode_sel,
  input  logic        btn_next,
  input  logic        pause,
  input  logic [1:0]  sw_width,
  input  logic [11:0] sw_rgb,
  output logic [1:0]  side_width,
  output logic [11:0] square_rgb,
  output logic        step_tick
);

  mode_e       mode_q;
  mode_e       mode_new;
  logic        pending_q;
  logic [1:0]  size_idx_q, size_idx_nxt;
  logic        size_down_q, size_down_nxt;
  logic [2:0]  color_idx_q, color_idx_nxt;
  logic [1:0]  side_width_q;
  logic [11:0] square_rgb_q;
  logic        step_tick_q;

  logic mode_change;
  logic timer_en;
  logic auto_step;
  logic step_req;
  logic do_size;
  logic do_color;

  square_step_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (mode_change),
    .en        (timer_en),
    .frame_tick(frame_tick),
    .step      (auto_step)
  );

  always_comb begin
    mode_new    = mode_e'(mode_sel);
    mode_change = frame_tick && (mode_new != mode_q);
    timer_en    = (mode_q != ModeManual) && !pause;
    // The step decision follows the mode being latched on this tick.
    step_req    = frame_tick && (mode_new != ModeManual) &&
                  (auto_step || pending_q || btn_next);
    do_size     = step_req && size_step_is_size(mode_new);
    do_color    = step_req && size_step_is_color(mode_new);

    size_idx_nxt  = size_idx_q;
    size_down_nxt = size_down_q;
    if (size_down_q) begin
      size_idx_nxt = size_idx_q - 2'd1;
      if (size_idx_nxt == W16) size_down_nxt = 1'b0;
    end else begin
      size_idx_nxt = size_idx_q + 2'd1;
      if (size_idx_nxt == W128) size_down_nxt = 1'b1;
    end
    color_idx_nxt = color_idx_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= ModeManual;
      pending_q    <= 1'b0;
      size_idx_q   <= W16;
      size_down_q  <= 1'b0;
      color_idx_q  <= 3'd0;
      side_width_q <= W16;
      square_rgb_q <= 12'h000;
      step_tick_q  <= 1'b0;
    end else begin
      pending_q   <= frame_tick ? 1'b0 : (pending_q || btn_next);
      step_tick_q <= step_req;
      if (frame_tick) begin
        mode_q <= mode_new;
        unique case (mode_new)
          ModeManual: begin
            side_width_q <= sw_width;
            square_rgb_q <= sw_rgb;
          end
          default: begin
            if (do_size) begin
              size_idx_q   <= size_idx_nxt;
              size_down_q  <= size_down_nxt;
              side_width_q <= size_idx_nxt;
            end
            if (do_color) begin
              color_idx_q  <= color_idx_nxt;
              square_rgb_q <= Palette[color_idx_nxt];
            end
          end
        endcase
      end
    end
  end

  assign side_width = side_width_q;
  assign square_rgb = square_rgb_q;
  assign step_tick  = step_tick_q;

endmodule
